// File: rtl/rs_dispatch_alloc_pkg.sv
// rs_dispatch_alloc_pkg: RS encodings and default sizing shared by the dispatch allocator and its bench
package rs_dispatch_alloc_pkg;
  typedef enum logic [1:0] {
    RS_ALU    = 2'd0,
    RS_MUL    = 2'd1,
    RS_LDST   = 2'd2,
    RS_BRANCH = 2'd3
  } rs_e;
  localparam int DP_W_DEF     = 2;
  localparam int RS_NUM_DEF   = 4;
  localparam int RS_DEPTH_DEF = 8;
  localparam int REL_MAX_DEF  = 1;
endpackage

// File: rtl/rs_credit_ctr.sv
// rs_credit_ctr: free-entry counter for one reservation station
// Ports: i_clk/i_rst_n clock and async active-low reset; i_flush reloads to RS_DEPTH;
//   i_take slots granted this cycle; i_rel entries released this cycle;
//   o_credit registered free count; o_clamp sticky flag, set when a release overshoots RS_DEPTH.
module rs_credit_ctr #(
  parameter int RS_DEPTH = 8,
  parameter int NUM_W    = 2,
  parameter int REL_W    = 1,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [NUM_W-1:0] i_take,
  input  logic [REL_W-1:0] i_rel,
  output logic [CNT_W-1:0] o_credit,
  output logic             o_clamp
);
  localparam int SW = CNT_W + 1;
  logic [SW-1:0] sum;
  logic          over;
  // One spare bit so an over-release is visible before clamping
  assign sum  = {1'b0, o_credit} - SW'(i_take) + SW'(i_rel);
  assign over = sum > SW'(RS_DEPTH);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_credit <= CNT_W'(RS_DEPTH);
      o_clamp  <= 1'b0;
    end else if (i_flush) begin
      o_credit <= CNT_W'(RS_DEPTH);
    end else begin
      o_credit <= over ? CNT_W'(RS_DEPTH) : sum[CNT_W-1:0];
      o_clamp  <= o_clamp | over;
    end
  end
endmodule

// File: rtl/rs_dispatch_alloc.sv
// rs_dispatch_alloc: in-order steering of dispatch slots onto credit-limited reservation stations
// Ports: i_clk/i_rst_n clock and async active-low reset; i_dp_vld/i_dp_rs_sel per-slot valid and target RS;
//   i_rs_rel per-RS release count; i_flush empties all RS; o_dp_gnt per-slot grant; o_rs_req RS write
//   request bit [r*DP_W+k]; o_rs_req_num per-RS grant count; o_dp_stall some valid slot not granted;
//   o_rs_credit registered free counts; o_credit_err sticky over-release flag.
module rs_dispatch_alloc
  import rs_dispatch_alloc_pkg::*;
#(
  parameter int DP_W     = DP_W_DEF,
  parameter int RS_NUM   = RS_NUM_DEF,
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int REL_MAX  = REL_MAX_DEF,
  parameter int SEL_W    = $clog2(RS_NUM),
  parameter int CNT_W    = $clog2(RS_DEPTH + 1),
  parameter int NUM_W    = $clog2(DP_W + 1),
  parameter int REL_W    = $clog2(REL_MAX + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DP_W-1:0]         i_dp_vld,
  input  logic [DP_W*SEL_W-1:0]   i_dp_rs_sel,
  input  logic [RS_NUM*REL_W-1:0] i_rs_rel,
  input  logic                    i_flush,
  output logic [DP_W-1:0]         o_dp_gnt,
  output logic [RS_NUM*DP_W-1:0]  o_rs_req,
  output logic [RS_NUM*NUM_W-1:0] o_rs_req_num,
  output logic                    o_dp_stall,
  output logic [RS_NUM*CNT_W-1:0] o_rs_credit,
  output logic                    o_credit_err
);
  logic [CNT_W-1:0] credit [RS_NUM];
  logic [NUM_W-1:0] need   [RS_NUM];
  logic [NUM_W-1:0] num    [RS_NUM];
  logic [RS_NUM-1:0] clamp;
  logic [SEL_W-1:0] s;
  logic             ok;
  logic             blocked;
  // Walk slots oldest first; need[] is the running per-RS demand, blocked latches the first failure.
  // A valid slot whose sel matches no RS leaves ok low and therefore blocks like a credit miss.
  always_comb begin
    o_dp_gnt = '0;
    o_rs_req = '0;
    blocked  = 1'b0;
    s        = '0;
    ok       = 1'b0;
    for (int r = 0; r < RS_NUM; r++) begin
      need[r] = '0;
      num[r]  = '0;
    end
    for (int k = 0; k < DP_W; k++) begin
      s  = i_dp_rs_sel[k*SEL_W +: SEL_W];
      ok = 1'b0;
      if (i_dp_vld[k]) begin
        for (int r = 0; r < RS_NUM; r++) begin
          if (int'(s) == r) begin
            need[r] = need[r] + NUM_W'(1);
            ok = !blocked && !i_flush && int'(need[r]) <= int'(credit[r]);
            num[r] = ok ? num[r] + NUM_W'(1) : num[r];
            o_rs_req[r*DP_W+k] = ok;
          end
        end
        blocked = blocked | !ok;
      end
      o_dp_gnt[k] = ok;
    end
  end
  for (genvar r = 0; r < RS_NUM; r++) begin : g_ctr
    rs_credit_ctr #(
      .RS_DEPTH(RS_DEPTH),
      .NUM_W   (NUM_W),
      .REL_W   (REL_W),
      .CNT_W   (CNT_W)
    ) u_ctr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_take  (num[r]),
      .i_rel   (i_rs_rel[r*REL_W +: REL_W]),
      .o_credit(credit[r]),
      .o_clamp (clamp[r])
    );
    assign o_rs_credit[r*CNT_W +: CNT_W]   = credit[r];
    assign o_rs_req_num[r*NUM_W +: NUM_W] = num[r];
  end
  assign o_dp_stall   = |(i_dp_vld & ~o_dp_gnt);
  assign o_credit_err = |clamp;
endmodule

// File: tb/tb_rs_dispatch_alloc.sv
// tb_rs_dispatch_alloc: vector table, corner sequences and randomized run against a credit model
module tb_rs_dispatch_alloc;
  import rs_dispatch_alloc_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  vld = '0;
  logic [3:0]  sel = '0;
  logic [3:0]  rel = '0;
  logic        fl = 1'b0;
  logic [1:0]  gnt;
  logic [7:0]  req;
  logic [7:0]  num;
  logic        stall;
  logic [15:0] cred;
  logic        err;
  int n_chk = 0;
  int n_fail = 0;
  int mcred [4];
  bit merr;
  rs_dispatch_alloc dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dp_vld(vld), .i_dp_rs_sel(sel), .i_rs_rel(rel),
    .i_flush(fl), .o_dp_gnt(gnt), .o_rs_req(req), .o_rs_req_num(num), .o_dp_stall(stall),
    .o_rs_credit(cred), .o_credit_err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  vld;
    logic [3:0]  sel;
    logic [3:0]  rel;
    logic        fl;
    logic [1:0]  gnt;
    logic [7:0]  req;
    logic [7:0]  num;
    logic        stall;
    logic [15:0] cred;
  } vec_t;
  vec_t tbl [12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [3:0] s, input logic [3:0] r, input logic f);
    @(negedge clk);
    vld = v; sel = s; rel = r; fl = f;
    #1;
  endtask
  function automatic logic [15:0] mpack();
    logic [15:0] p;
    for (int r = 0; r < 4; r++) p[r*4 +: 4] = 4'(mcred[r]);
    return p;
  endfunction
  // Reference: slots in order, each must fit in its RS credit counting older slots to the same RS
  task automatic model_eval(output logic [1:0] g, output logic [7:0] rq, output logic [7:0] nm);
    int need [4];
    bit blk;
    int s;
    need = '{default: 0};
    blk = 0; g = '0; rq = '0; nm = '0;
    for (int k = 0; k < 2; k++) begin
      if (vld[k]) begin
        s = int'(sel[k*2 +: 2]);
        need[s]++;
        if (!blk && !fl && need[s] <= mcred[s]) begin
          g[k] = 1'b1;
          rq[s*2+k] = 1'b1;
          nm[s*2 +: 2] = nm[s*2 +: 2] + 2'd1;
        end else blk = 1;
      end
    end
  endtask
  task automatic model_update(input logic [7:0] nm);
    int c;
    for (int r = 0; r < 4; r++) begin
      if (fl) mcred[r] = 8;
      else begin
        c = mcred[r] - int'(nm[r*2 +: 2]) + int'(rel[r]);
        if (c > 8) begin c = 8; merr = 1; end
        mcred[r] = c;
      end
    end
  endtask
  initial begin
    logic [1:0] eg;
    logic [7:0] erq, enm;
    tbl[0]  = '{2'b11, {RS_MUL, RS_ALU}, 4'b0000, 1'b0, 2'b11, 8'h09, 8'h05, 1'b0, 16'h8877};
    tbl[1]  = '{2'b11, {RS_ALU, RS_ALU}, 4'b0000, 1'b0, 2'b11, 8'h03, 8'h02, 1'b0, 16'h8875};
    tbl[2]  = '{2'b11, {RS_ALU, RS_ALU}, 4'b0000, 1'b0, 2'b11, 8'h03, 8'h02, 1'b0, 16'h8873};
    tbl[3]  = '{2'b11, {RS_ALU, RS_ALU}, 4'b0000, 1'b0, 2'b11, 8'h03, 8'h02, 1'b0, 16'h8871};
    tbl[4]  = '{2'b11, {RS_ALU, RS_ALU}, 4'b0000, 1'b0, 2'b01, 8'h01, 8'h01, 1'b1, 16'h8870};
    tbl[5]  = '{2'b11, {RS_MUL, RS_ALU}, 4'b0001, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 16'h8871};
    tbl[6]  = '{2'b11, {RS_MUL, RS_ALU}, 4'b0000, 1'b0, 2'b11, 8'h09, 8'h05, 1'b0, 16'h8860};
    tbl[7]  = '{2'b10, {RS_ALU, RS_MUL}, 4'b0000, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 16'h8860};
    tbl[8]  = '{2'b10, {RS_MUL, RS_ALU}, 4'b0000, 1'b0, 2'b10, 8'h08, 8'h04, 1'b0, 16'h8850};
    tbl[9]  = '{2'b01, {RS_ALU, RS_LDST}, 4'b0100, 1'b0, 2'b01, 8'h10, 8'h10, 1'b0, 16'h8850};
    tbl[10] = '{2'b11, {RS_ALU, RS_ALU}, 4'b1111, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 16'h8888};
    tbl[11] = '{2'b00, {RS_ALU, RS_ALU}, 4'b0000, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 16'h8888};
    #12;
    check("reset_credit", 32'(cred), 32'h8888);
    check("reset_err", 32'(err), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].rel, tbl[i].fl);
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_num", i), 32'(num), 32'(tbl[i].num));
      check($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_credit", i), 32'(cred), 32'(tbl[i].cred));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'h0);
    end
    drive(2'b00, 4'b0000, 4'b1000, 1'b0);
    @(posedge clk); #1;
    check("overrel_credit", 32'(cred), 32'h8888);
    check("overrel_err", 32'(err), 32'h1);
    drive(2'b00, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk); #1;
    check("err_sticky", 32'(err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, {RS_ALU, RS_ALU}, 4'b0000, 1'b0);
      @(posedge clk); #1;
    end
    check("alu_drained", 32'(cred), 32'h8880);
    drive(2'b11, {RS_MUL, RS_ALU}, 4'b0000, 1'b0);
    check("drained_stall", 32'(stall), 32'h1);
    check("drained_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stall), 32'h0);
    check("rst_mid_gnt", 32'(gnt), 32'h3);
    check("rst_mid_credit", 32'(cred), 32'h8888);
    check("rst_mid_err", 32'(err), 32'h0);
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mcred = '{8, 8, 8, 8};
    merr = 0;
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 4'($urandom),
            {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
            $urandom_range(0, 24) == 0);
      model_eval(eg, erq, enm);
      check("rnd_gnt", 32'(gnt), 32'(eg));
      check("rnd_req", 32'(req), 32'(erq));
      check("rnd_num", 32'(num), 32'(enm));
      check("rnd_stall", 32'(stall), 32'(|(vld & ~eg)));
      model_update(enm);
      @(posedge clk); #1;
      check("rnd_credit", 32'(cred), 32'(mpack()));
      check("rnd_err", 32'(err), 32'(merr));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
